// File: rtl/muldiv_unit_if.sv
// Request/response bundle between execute-stage control and muldiv_unit.
// Control is the master; it drives the request side and samples busy/done/results.
interface muldiv_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Latency WIDTH+2 from accepted start to done; start is ignored while busy, accepted in IDLE or DONE.
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic             is_div, a_neg, b_neg, accept, div_ge;
    logic [WIDTH-1:0] abs_a, abs_b, div_diff;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign is_div   = op_q[1];
    assign a_neg    = op_q[0] & a_q[WIDTH-1];
    assign b_neg    = op_q[0] & b_q[WIDTH-1];
    assign abs_a    = a_neg ? -a_q : a_q;
    assign abs_b    = b_neg ? -b_q : b_q;
    assign accept   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // hi_q is the running product high half (mul) or partial remainder (div);
    // lo_q shifts out multiplier bits / dividend bits and shifts in quotient bits.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, dvs_q};
    assign div_diff  = div_shift[WIDTH-1:0] - dvs_q;
    assign prod      = {hi_q, lo_q};
    assign prod_neg  = -prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dvs_d    = dvs_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            S_PREP: begin
                hi_d     = '0;
                cnt_d    = '0;
                lo_d     = is_div ? abs_a : abs_b;
                dvs_d    = is_div ? abs_b : abs_a;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div) begin
                    {res_hi_d, res_lo_d} = neg_lo_q ? prod_neg : prod;
                    dbz_d = 1'b0;
                end else if (b_q == '0) begin
                    res_lo_d = '1;
                    res_hi_d = a_q;
                    dbz_d    = 1'b1;
                end else begin
                    // Most-negative / -1 lands on 0x80..0 naturally: its negation wraps to itself.
                    res_lo_d = neg_lo_q ? -lo_q : lo_q;
                    res_hi_d = neg_hi_q ? -hi_q : hi_q;
                    dbz_d    = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            op_d    = bus.op;
            a_d     = bus.a;
            b_d     = bus.b;
            busy_d  = 1'b1;
            state_d = S_PREP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dvs_q    <= dvs_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.result_lo   = res_lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative, parametrised multiply/divide unit.
- Extends the datapath ALU with signed and unsigned multiply and divide at any operand width.
- Sits beside the ALU in the execute stage. Control holds the datapath while Busy is high and captures ResultHi/ResultLo when Done pulses.
- Uses a shift-add multiplier and a restoring divider, one bit per cycle, so latency is fixed and data-independent.

## Interface
- WIDTH, 16: operand width in bits. Legal range 4..64.
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation. Sampled only when Busy=0.
- Op  input  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed). Latched with Start.
- A  input  WIDTH  multiplicand or dividend. Latched with Start.
- B  input  WIDTH  multiplier or divisor. Latched with Start.
- Busy  output  1  operation in progress. New Start is ignored while high.
- Done  output  1  one-cycle pulse; results are valid from this cycle onward.
- ResultHi  output  WIDTH  product upper half, or remainder.
- ResultLo  output  WIDTH  product lower half, or quotient.
- DivByZero  output  1  set with Done when a divide had B=0.

## Operation
- FSM states:
  - IDLE
  - PREP: take absolute values for signed ops; record result signs.
  - RUN: WIDTH iterations, counter of $clog2(WIDTH+1) bits.
  - FIX: negate results as required; load outputs.
  - DONE: Done=1 for one cycle, Busy=0, then IDLE.
- Transitions:
  - IDLE→PREP on Start.
  - PREP→RUN unconditionally.
  - RUN→FIX when the counter reaches WIDTH.
  - FIX→DONE unconditionally.
  - DONE→PREP if Start=1, otherwise DONE→IDLE.
- Start is accepted in IDLE and in DONE. Start in PREP, RUN or FIX is ignored, and the latched operands and Op are unaffected.
- MULU: {ResultHi,ResultLo} = A×B, unsigned, full 2·WIDTH bits.
- MUL: two's-complement product, full 2·WIDTH bits, sign-correct.
- DIVU: ResultLo = A/B, ResultHi = A mod B.
- DIV:
  - Quotient truncates toward zero.
  - Remainder takes the sign of A.
  - A = A_q×B + R always holds.
- Divide by zero (both divide ops): ResultLo = all ones, ResultHi = A, DivByZero=1. Latency is unchanged.
- Signed overflow (A = most negative, B = −1): ResultLo = most negative, ResultHi = 0, DivByZero=0.
- For multiply ops, DivByZero=0.
- ResultHi, ResultLo and DivByZero hold their values from Done until the FIX state of the next accepted operation. They are not cleared on Start.
- Reset values: Busy 0, Done 0, ResultHi 0, ResultLo 0, DivByZero 0, FSM in IDLE.

## Timing
- Start is accepted at rising edge E0.
- Busy goes high after E0 and stays high through PREP, RUN and FIX (WIDTH+2 cycles).
- Done is high between E(WIDTH+2) and E(WIDTH+3). Busy is low in that same cycle.
- Latency from Start to Done is WIDTH+2 cycles: 18 cycles for WIDTH=16. Latency does not depend on the operand values.
- Throughput: a Start held high during the DONE cycle is accepted at E(WIDTH+3). The next Done then follows WIDTH+2 cycles later, with no idle cycle between operations.
- Reset_n low at any time, including mid-RUN:
  - All outputs and the FSM go to their reset values immediately, without waiting for a clock edge.
  - The in-flight operation is discarded and no Done is produced for it.
- The first Start is sampled at the first rising edge after Reset_n deasserts.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=16.
- MULU A=0xFFFF, B=0xFFFF → ResultHi=0xFFFE, ResultLo=0x0001, Done exactly 18 cycles after the Start edge, DivByZero=0.
- MUL A=0xFFFD (−3), B=0x0005 → ResultHi=0xFFFF, ResultLo=0xFFF1.
- MUL A=0x8000, B=0x8000 → ResultHi=0x4000, ResultLo=0x0000.
- DIVU A=100, B=7 → ResultLo=0x000E, ResultHi=0x0002.
- DIV A=0xFFF9 (−7), B=2 → ResultLo=0xFFFD, ResultHi=0xFFFF.
- DIVU A=0x1234, B=0 → ResultLo=0xFFFF, ResultHi=0x1234, DivByZero=1.
- DIV A=0x8000, B=0xFFFF → ResultLo=0x8000, ResultHi=0x0000, DivByZero=0.
- Start pulsed with different operands at cycles 5 and 10 of a running op → those requests are ignored and the original result is unchanged. Start held in the DONE cycle → second op accepted, its Done arrives 18 cycles later.
- Reset_n low at RUN cycle 8 → Busy and Done are 0 and results are 0 immediately, and no Done appears for the discarded op. After Reset_n release, a fresh MULU 3×4 → ResultLo=0x000C.
